storebyte_buf: RTL
==================

Name: storebyte_buf

Overview:
- Store-side counterpart of the load extractor in the MEM stage.
- Converts sw/sh/sb into word-aligned bus writes with byte enables and lane-replicated data, and flags AdES for illegal stores.
- Queues accepted stores in a small in-order write buffer that drains to the DM/timer/stall-register bridge over a valid/ready handshake.
- Stalls the pipeline when the buffer is full, and flags loads that hit a pending store.

Parameters:
- DEPTH, 2, write-buffer entries (power of two, ≥2)
- CW, 2, occupancy counter width = log2(DEPTH)+1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- addr  in  32  store byte address from ALU
- LSOp  in  2  11 word, 10 half, 01 byte, 00 none
- WD_in  in  32  rt value to store
- MemWrite  in  1  store request; caller already gates it with exception/interrupt kill
- ld_addr  in  32  current load address
- ld_en  in  1  load in MEM this cycle
- MEM_EXC_AdES  out  1  store address exception (combinational)
- store_stall  out  1  freeze MEM and earlier stages
- ld_conflict  out  1  load word matches a pending entry; caller stalls
- bus_valid  out  1  head entry valid
- bus_ready  in  1  bridge accepts head
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated data
- bus_be  out  4  byte enables
- buf_count  out  CW  occupancy

Behaviour:
- Reset (reset==0 at posedge): all entries invalid; head/tail pointers = 0; count = 0; bus_valid = 0; bus_addr, bus_wdata, bus_be = 0. Reset mid-drain discards every entry, including an un-acked head.
- Byte enables:
  - word: 1111
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100
  - byte: 0001 << addr[1:0]
- Data: word = WD_in; half = {2{WD_in[15:0]}}; byte = {4{WD_in[7:0]}}.
- AdES = MemWrite && LSOp!=0 && (align || range || timer):
  - align: word with addr[1:0]!=0, or half with addr[0]=1
  - range: addr outside DM 0x0000–0x2fff, TC0 0x7f00–0x7f0b, TC1 0x7f10–0x7f1b, Stall 0x7f20–0x7f23
  - timer: addr in TC0/TC1 and (LSOp!=11 or addr[3:2]==2'b10, i.e. COUNT register is read-only)
- full = (count==DEPTH), taken from the registered count only.
- push = MemWrite && LSOp!=0 && !AdES && !full. A faulting store is never queued.
- store_stall = MemWrite && LSOp!=0 && !AdES && full. A pop in the same cycle does not unblock the push; it is accepted the next cycle (1-cycle bubble, by design).
- pop = bus_valid && bus_ready. bus_valid = (count!=0).
- Handshake: head fields and bus_valid stay stable until pop; bus_valid never drops without a pop.
- Push on an empty buffer: bus_valid rises the cycle after push (1-cycle latency).
- Simultaneous push and pop (count not full): count unchanged; both pointers advance, wrapping modulo DEPTH.
- Order: strictly FIFO; no merging or coalescing.
- ld_conflict = ld_en && some valid entry has entry.addr[31:2]==ld_addr[31:2]. Byte enables are ignored (conservative). Combinational, deasserts once that entry pops.
- LSOp==00 with MemWrite: ignored, no AdES, no stall.

Decomposition:
- Shared package holds:
  - LSOp encodings (LS_NONE/BYTE/HALF/WORD)
  - address-map constants (DM/TC0/TC1/Stall start and end), shared with the load side
  - timer COUNT register offset
  - store-entry struct {addr[31:2], wdata, be}
- Sub-module: ades_check, the combinational range/align/timer classifier. Its range logic is shared in form with the load-side AdEL check.

Test Plan:
- sb 0xAABBCCDD @0x0000_0013, bus_ready=1 → next cycle bus_valid=1, bus_addr=0x0000_0010, bus_be=1000, bus_wdata=0xDDDDDDDD; popped that cycle; count returns to 0.
- sh @0x0000_0002 (data 0x1234_5678), sw @0x0000_0004, sw @0x0000_0008 back-to-back, bus_ready=0 → first two queued (count=2); third store_stall=1. Raise bus_ready one cycle → one pop; third accepted the following cycle. Drain order: 0x0 be 1100 data 0x56785678, then 0x4, then 0x8.
- sw @0x0000_0006, sh @0x0000_3000, sb @0x0000_7f04, sw @0x0000_7f08 → AdES=1 for each; count stays 0; bus_valid stays 0. sw @0x0000_7f04 → AdES=0, queued.
- Queue sw @0x0000_0100 with bus_ready=0; lw @0x0000_0100 → ld_conflict=1. lw @0x0000_0104 → 0. After pop, lw @0x0000_0100 → 0.
- Queue 2 entries; assert reset=0 for one cycle while bus_valid=1, bus_ready=0 → bus_valid=0, count=0, no further pops after release.
- Steady push+pop every cycle for 10 stores with bus_ready=1 → count holds at 1, pointers wrap, all 10 appear in order with correct be/data.

Source files
------------

// File: rtl/storebyte_buf_pkg.sv
// Shared definitions for the MEM-stage store path: access sizes, the data
// address map (also used by the load side) and the write-buffer entry layout.
package storebyte_buf_pkg;

    localparam logic [1:0] LS_NONE = 2'b00;
    localparam logic [1:0] LS_BYTE = 2'b01;
    localparam logic [1:0] LS_HALF = 2'b10;
    localparam logic [1:0] LS_WORD = 2'b11;

    localparam logic [31:0] DM_START    = 32'h0000_0000;
    localparam logic [31:0] DM_END      = 32'h0000_2fff;
    localparam logic [31:0] TC0_START   = 32'h0000_7f00;
    localparam logic [31:0] TC0_END     = 32'h0000_7f0b;
    localparam logic [31:0] TC1_START   = 32'h0000_7f10;
    localparam logic [31:0] TC1_END     = 32'h0000_7f1b;
    localparam logic [31:0] STALL_START = 32'h0000_7f20;
    localparam logic [31:0] STALL_END   = 32'h0000_7f23;

    // Word offset of the read-only COUNT register inside each timer block.
    localparam logic [1:0] TC_COUNT_OFF = 2'b10;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_entry_t;

    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/storebyte_buf_ades_check.sv
// Combinational store-address classifier: misalignment, unmapped address and
// illegal timer accesses. Faults are raw; the caller qualifies them with the request.
module ades_check
    import storebyte_buf_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  lsop,
    output logic        align_err,
    output logic        range_err,
    output logic        timer_err
);

    logic in_dm;
    logic in_tc;
    logic in_stall;

    always_comb begin
        in_dm     = in_window(addr, DM_START, DM_END);
        in_tc     = in_window(addr, TC0_START, TC0_END) || in_window(addr, TC1_START, TC1_END);
        in_stall  = in_window(addr, STALL_START, STALL_END);
        range_err = !(in_dm || in_tc || in_stall);
        align_err = ((lsop == LS_WORD) && (addr[1:0] != 2'b00)) ||
                    ((lsop == LS_HALF) && addr[0]);
        // Timers take only full-word writes, and never to COUNT.
        timer_err = in_tc && ((lsop != LS_WORD) || (addr[3:2] == TC_COUNT_OFF));
    end

endmodule

// File: rtl/storebyte_buf.sv
// MEM-stage store formatter and in-order write buffer draining to the
// DM/timer/stall-register bridge over a valid/ready handshake.
module storebyte_buf
    import storebyte_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic [1:0]    LSOp,
    input  logic [31:0]   WD_in,
    input  logic          MemWrite,
    input  logic [31:0]   ld_addr,
    input  logic          ld_en,
    output logic          MEM_EXC_AdES,
    output logic          store_stall,
    output logic          ld_conflict,
    output logic          bus_valid,
    input  logic          bus_ready,
    output logic [31:0]   bus_addr,
    output logic [31:0]   bus_wdata,
    output logic [3:0]    bus_be,
    output logic [CW-1:0] buf_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic align_err;
    logic range_err;
    logic timer_err;

    ades_check u_ades_check (
        .addr      (addr),
        .lsop      (LSOp),
        .align_err (align_err),
        .range_err (range_err),
        .timer_err (timer_err)
    );

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    st_entry_t        mem_q [DEPTH];
    st_entry_t        mem_d [DEPTH];

    logic      st_req;
    logic      full;
    logic      push;
    logic      pop;
    logic      hit;
    st_entry_t new_entry;
    st_entry_t head_entry;
    logic      unused_ld_bits;

    assign unused_ld_bits = ^ld_addr[1:0];

    always_comb begin
        new_entry.addr  = addr[31:2];
        new_entry.wdata = WD_in;
        new_entry.be    = 4'b0000;
        case (LSOp)
            LS_WORD: begin
                new_entry.be    = 4'b1111;
                new_entry.wdata = WD_in;
            end
            LS_HALF: begin
                new_entry.be    = addr[1] ? 4'b1100 : 4'b0011;
                new_entry.wdata = {2{WD_in[15:0]}};
            end
            LS_BYTE: begin
                new_entry.be    = 4'b0001 << addr[1:0];
                new_entry.wdata = {4{WD_in[7:0]}};
            end
            default: ;
        endcase
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot for this push.
    always_comb begin
        st_req       = MemWrite && (LSOp != LS_NONE);
        MEM_EXC_AdES = st_req && (align_err || range_err || timer_err);
        full         = (count_q == CW'(DEPTH));
        push         = st_req && !MEM_EXC_AdES && !full;
        store_stall  = st_req && !MEM_EXC_AdES && full;
        bus_valid    = (count_q != '0);
        pop          = bus_valid && bus_ready;
    end

    always_comb begin
        head_entry = mem_q[head_q];
        bus_addr   = bus_valid ? {head_entry.addr, 2'b00} : 32'h0;
        bus_wdata  = bus_valid ? head_entry.wdata : 32'h0;
        bus_be     = bus_valid ? head_entry.be : 4'b0000;
        buf_count  = count_q;
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i].addr == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
        ld_conflict = ld_en && hit;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[tail_q]   = new_entry;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload carries no reset; it is only observed through valid/count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
